// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: shares one half-duplex SPI master between NUM_REQ requesters.
// Define SPI_ARB_STRICT_PRIO_EN for fixed-priority arbitration instead of round-robin.
module spi_txn_arbiter #(
    parameter int NUM_REQ               = 2,
    parameter int DATA_WIDTH            = 32,
    parameter int TRANSACTION_LEN_WIDTH = 6,
    parameter int WAIT_WIDTH            = 16
) (
    input  logic                                     fabric_clk,
    input  logic                                     reset_n,
    input  logic [NUM_REQ-1:0]                       req_valid,
    output logic [NUM_REQ-1:0]                       req_ready,
    input  logic [NUM_REQ*TRANSACTION_LEN_WIDTH-1:0] req_length,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]            req_data,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]            req_mask,
    output logic [NUM_REQ-1:0]                       rsp_valid,
    output logic [DATA_WIDTH-1:0]                    rsp_data,
    input  logic [WAIT_WIDTH-1:0]                    cfg_wait_cycles,
    output logic                                     busy,
    output logic [TRANSACTION_LEN_WIDTH-1:0]         spi_transaction_length,
    output logic [DATA_WIDTH-1:0]                    spi_transaction_data,
    output logic [DATA_WIDTH-1:0]                    spi_transaction_rw_mask,
    input  logic [DATA_WIDTH-1:0]                    spi_transaction_read_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TLW   = TRANSACTION_LEN_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESPOND
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      own_q, own_d;
    logic [TLW-1:0]        len_q, len_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [WAIT_WIDTH-1:0] cnt_q, cnt_d;

    logic                  gnt_found;
    logic [IDX_W-1:0]      gnt_idx;
    logic [TLW-1:0]        len_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] mask_arr [NUM_REQ];

    // Unpack the flattened per-requester payload buses
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            len_arr[i]  = req_length[i*TLW +: TLW];
            data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            mask_arr[i] = req_mask[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Pick the winning requester: first valid one scanning from the start point
    always_comb begin
        logic [IDX_W:0] sum;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SPI_ARB_STRICT_PRIO_EN
            sum = (IDX_W+1)'(k);
`else
            sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
`endif
            if (!gnt_found && req_valid[sum[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = sum[IDX_W-1:0];
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            len_q   <= len_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept, issue, timed wait, respond
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        len_d   = len_q;
        data_d  = data_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    own_d  = gnt_idx;
                    len_d  = len_arr[gnt_idx];
                    data_d = data_arr[gnt_idx];
                    mask_d = mask_arr[gnt_idx];
                    // The master needs at least two idle cycles between pulses
                    if (cfg_wait_cycles < WAIT_WIDTH'(2)) begin
                        cnt_d = WAIT_WIDTH'(2);
                    end else begin
                        cnt_d = cfg_wait_cycles;
                    end
                    if (len_arr[gnt_idx] == '0) begin
                        state_d = S_RESPOND;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - WAIT_WIDTH'(1);
                if (cnt_q == WAIT_WIDTH'(1)) begin
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
`ifdef SPI_ARB_STRICT_PRIO_EN
                ptr_d = '0;
`else
                if (own_q == IDX_W'(NUM_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = own_q + IDX_W'(1);
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        req_ready               = '0;
        rsp_valid               = '0;
        rsp_data                = '0;
        busy                    = (state_q != S_IDLE);
        spi_transaction_length  = '0;
        spi_transaction_data    = data_q;
        spi_transaction_rw_mask = mask_q;
        if (state_q == S_IDLE && gnt_found && reset_n) begin
            req_ready[gnt_idx] = 1'b1;
        end
        if (state_q == S_ISSUE) begin
            spi_transaction_length = len_q;
        end
        if (state_q == S_RESPOND) begin
            rsp_valid[own_q] = 1'b1;
            if (len_q != '0) begin
                rsp_data = spi_transaction_read_data;
            end
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: vector table, corner sequences and random traffic
// checked every cycle against a transaction-level model.
module tb_spi_txn_arbiter;

    localparam int N   = 2;
    localparam int DW  = 32;
    localparam int TLW = 6;
    localparam int WW  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*TLW-1:0]  req_length = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N*DW-1:0]   req_mask = '0;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [WW-1:0]     cfg_wait = '0;
    logic              busy;
    logic [TLW-1:0]    spi_len;
    logic [DW-1:0]     spi_data;
    logic [DW-1:0]     spi_mask;
    logic [DW-1:0]     rdata = '0;

    spi_txn_arbiter #(
        .NUM_REQ(N),
        .DATA_WIDTH(DW),
        .TRANSACTION_LEN_WIDTH(TLW),
        .WAIT_WIDTH(WW)
    ) dut (
        .fabric_clk(clk),
        .reset_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_length(req_length),
        .req_data(req_data),
        .req_mask(req_mask),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .cfg_wait_cycles(cfg_wait),
        .busy(busy),
        .spi_transaction_length(spi_len),
        .spi_transaction_data(spi_data),
        .spi_transaction_rw_mask(spi_mask),
        .spi_transaction_read_data(rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // events observed at the most recent sample point
    bit   acc_flag = 0;
    int   acc_idx = 0;
    int   acc_cyc = 0;
    bit   rsp_flag = 0;
    int   rsp_idx = 0;
    int   rsp_cyc = 0;
    logic [DW-1:0] rsp_dat = '0;
    int   rsp_cnt = 0;
    int   pulse_cnt = 0;
    int   pulse_cyc = 0;
    int   pulse_len = 0;
    int   acc_log[$];

    // transaction-level model
    bit   m_act = 0;
    int   m_acc = 0;
    int   m_rsp = 0;
    int   m_own = 0;
    int   m_ptr = 0;
    logic [TLW-1:0] m_len = '0;
    logic [DW-1:0]  m_data = '0;
    logic [DW-1:0]  m_mask = '0;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    function automatic int pick(logic [N-1:0] v, int p);
        int r;
        int j;
        r = -1;
        for (int k = 0; k < N; k++) begin
`ifdef SPI_ARB_STRICT_PRIO_EN
            j = k;
`else
            j = (p + k) % N;
`endif
            if (r < 0 && v[j]) r = j;
        end
        return r;
    endfunction

    // per-cycle sample: compare every output with the model, then advance it
    always @(negedge clk) begin
        logic [N-1:0]  e_rdy;
        logic [N-1:0]  e_rv;
        logic [DW-1:0] e_rd;
        logic          e_busy;
        logic [TLW-1:0] e_len;
        logic [106:0]  act_v;
        logic [106:0]  exp_v;
        int g;
        int w;
        e_rdy = '0; e_rv = '0; e_rd = '0; e_busy = 1'b0; e_len = '0;
        g = -1;
        if (!rst_n) begin
            m_act = 0; m_ptr = 0; m_len = '0; m_data = '0; m_mask = '0;
        end else begin
            e_busy = m_act;
            if (m_act && cyc == m_acc + 1 && m_len != 0) e_len = m_len;
            if (m_act && cyc == m_rsp) begin
                e_rv[m_own] = 1'b1;
                if (m_len != 0) e_rd = rdata;
            end
            if (!m_act) begin
                g = pick(req_valid, m_ptr);
                if (g >= 0) e_rdy[g] = 1'b1;
            end
        end
        exp_v = {e_rdy, e_rv, e_rd, e_busy, e_len, m_data, m_mask};
        act_v = {req_ready, rsp_valid, rsp_data, busy, spi_len, spi_data, spi_mask};
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL cycle_model cyc=%0d got %h want %h", cyc, act_v, exp_v);
        end
        if (rst_n) begin
            if (m_act && cyc == m_rsp) begin
                m_act = 0;
`ifdef SPI_ARB_STRICT_PRIO_EN
                m_ptr = 0;
`else
                m_ptr = (m_own + 1) % N;
`endif
            end
            if (g >= 0) begin
                m_act  = 1;
                m_acc  = cyc;
                m_own  = g;
                m_len  = req_length[g*TLW +: TLW];
                m_data = req_data[g*DW +: DW];
                m_mask = req_mask[g*DW +: DW];
                w = int'(cfg_wait);
                if (w < 2) w = 2;
                m_rsp = (m_len == 0) ? cyc + 1 : cyc + 2 + w;
            end
        end
        acc_flag = rst_n && (req_ready != '0);
        if (acc_flag) begin
            for (int i = 0; i < N; i++) if (req_ready[i]) acc_idx = i;
            acc_cyc = cyc;
            acc_log.push_back(acc_idx);
        end
        rsp_flag = (rsp_valid != '0);
        if (rsp_flag) begin
            for (int i = 0; i < N; i++) if (rsp_valid[i]) rsp_idx = i;
            rsp_cyc = cyc;
            rsp_dat = rsp_data;
            rsp_cnt++;
        end
        if (spi_len != '0) begin
            pulse_cnt++;
            pulse_cyc = cyc;
            pulse_len = int'(spi_len);
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pl(int i, logic [TLW-1:0] l, logic [DW-1:0] d, logic [DW-1:0] m);
        req_length[i*TLW +: TLW] = l;
        req_data[i*DW +: DW] = d;
        req_mask[i*DW +: DW] = m;
    endtask

    task automatic wait_acc(string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (acc_flag) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check({name, "_accept_timeout"}, 0, 1);
    endtask

    task automatic wait_rsp(string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (rsp_flag) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check({name, "_rsp_timeout"}, 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && busy; i++) step();
        check("drain_idle", busy, 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    typedef struct {
        int            idx;
        logic [TLW-1:0] len;
        logic [DW-1:0] data;
        logic [DW-1:0] mask;
        logic [WW-1:0] w;
        logic [DW-1:0] rd;
        int            lat;
        logic [DW-1:0] exp_rd;
    } vec_t;

    initial begin
        vec_t vt[6];
        bit ok;
        int t;
        int p0;
        int n0;
        int base;

        vt[0] = '{0, 6'd16, 32'h0000_A5A5, 32'hFFFF_0000, 16'd10, 32'h1234_5678, 12, 32'h1234_5678};
        vt[1] = '{1, 6'd8,  32'h0F0F_0F0F, 32'h0000_0000, 16'd0,  32'hDEAD_BEEF, 4,  32'hDEAD_BEEF};
        vt[2] = '{0, 6'd1,  32'h0000_0001, 32'hFFFF_FFFF, 16'd1,  32'h0BAD_C0DE, 4,  32'h0BAD_C0DE};
        vt[3] = '{1, 6'd0,  32'h0000_0055, 32'h0000_0000, 16'd10, 32'hCAFE_F00D, 1,  32'h0000_0000};
        vt[4] = '{0, 6'd63, 32'hFFFF_FFFF, 32'hAAAA_5555, 16'd2,  32'h1357_9BDF, 4,  32'h1357_9BDF};
        vt[5] = '{1, 6'd32, 32'h2468_ACE0, 32'h0F0F_0000, 16'd3,  32'hFEDC_BA98, 5,  32'hFEDC_BA98};

        // reset state
        step();
        step();
        check("reset_state", {busy, spi_len, rsp_valid, req_ready}, 0);
        check("reset_data", {spi_data, spi_mask}, 0);
        rst_n = 1'b1;
        step();

        // vector table
        for (int v = 0; v < 6; v++) begin
            set_pl(vt[v].idx, vt[v].len, vt[v].data, vt[v].mask);
            cfg_wait = vt[v].w;
            rdata = vt[v].rd;
            p0 = pulse_cnt;
            req_valid = N'(1) << vt[v].idx;
            wait_acc($sformatf("vec%0d", v), ok);
            if (ok) begin
                check($sformatf("vec%0d_grant", v), acc_idx, vt[v].idx);
                t = acc_cyc;
                req_valid = '0;
                wait_rsp($sformatf("vec%0d", v), ok);
                if (ok) begin
                    check($sformatf("vec%0d_latency", v), rsp_cyc - t, vt[v].lat);
                    check($sformatf("vec%0d_rsp_idx", v), rsp_idx, vt[v].idx);
                    check($sformatf("vec%0d_rsp_data", v), rsp_dat, vt[v].exp_rd);
                    if (vt[v].len != 0) begin
                        check($sformatf("vec%0d_pulses", v), pulse_cnt - p0, 1);
                        check($sformatf("vec%0d_pulse_cyc", v), pulse_cyc - t, 1);
                        check($sformatf("vec%0d_pulse_len", v), pulse_len, vt[v].len);
                    end else begin
                        check($sformatf("vec%0d_no_pulse", v), pulse_cnt - p0, 0);
                    end
                    check($sformatf("vec%0d_busy_after", v), busy, 0);
                    check($sformatf("vec%0d_held_data", v), {spi_data, spi_mask},
                          {vt[v].data, vt[v].mask});
                end
            end
            req_valid = '0;
            drain();
        end

        // reset in the middle of WAIT, with the pointer moved to 1
        set_pl(0, 6'd4, 32'h1, 32'h0);
        cfg_wait = 16'd2;
        req_valid = 2'b01;
        wait_acc("pre0", ok);
        req_valid = '0;
        wait_rsp("pre0", ok);
        set_pl(1, 6'd5, 32'h77, 32'h0);
        cfg_wait = 16'd20;
        req_valid = 2'b10;
        wait_acc("pre1", ok);
        req_valid = '0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_wait_ctl", {busy, spi_len, rsp_valid, req_ready}, 0);
        check("rst_mid_wait_data", {spi_data, spi_mask}, 0);
        step();
        step();
        rst_n = 1'b1;
        n0 = rsp_cnt;
        for (int i = 0; i < 30; i++) step();
        check("rst_no_rsp", rsp_cnt - n0, 0);
        set_pl(0, 6'd2, 32'h3, 32'h0);
        set_pl(1, 6'd2, 32'h4, 32'h0);
        cfg_wait = 16'd0;
        req_valid = 2'b11;
        wait_acc("rst_grant", ok);
        if (ok) check("rst_ptr_grant", acc_idx, 0);
        req_valid = '0;
        drain();

        // both requesters valid continuously for four grants
        pulse_reset();
        set_pl(0, 6'd3, 32'hA0, 32'h0);
        set_pl(1, 6'd3, 32'hB1, 32'h0);
        cfg_wait = 16'd0;
        base = acc_log.size();
        req_valid = 2'b11;
        for (int i = 0; i < 200 && acc_log.size() < base + 4; i++) step();
        req_valid = '0;
        check("rr_grant_count", acc_log.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < acc_log.size()) begin
`ifdef SPI_ARB_STRICT_PRIO_EN
                check($sformatf("order_%0d", i), acc_log[base+i], 0);
`else
                check($sformatf("order_%0d", i), acc_log[base+i], i % 2);
`endif
            end
        end
        drain();

        // withdrawal while busy
        set_pl(0, 6'd4, 32'h5, 32'h0);
        set_pl(1, 6'd7, 32'h6, 32'h0);
        cfg_wait = 16'd6;
        req_valid = 2'b01;
        wait_acc("wd0", ok);
        req_valid = 2'b10;
        step();
        step();
        step();
        req_valid = '0;
        n0 = acc_log.size();
        p0 = pulse_cnt;
        wait_rsp("wd0", ok);
        for (int i = 0; i < 10; i++) step();
        check("wd_no_ready", acc_log.size() - n0, 0);
        check("wd_no_issue", pulse_cnt - p0, 0);

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            step();
            if (acc_flag) req_valid[acc_idx] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    set_pl(i,
                           ($urandom_range(0, 3) == 0) ? '0 : TLW'($urandom_range(1, 63)),
                           $urandom(), $urandom());
                    req_valid[i] = 1'b1;
                end
            end
            cfg_wait = WW'($urandom_range(0, 5));
            rdata = $urandom();
        end
        req_valid = '0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
